candidate_accum: RTL and testbench

Parametrised popcount accumulator for the MapCell result stream. It combines 1, 2 or 3 consecutive result rows bitwise according to a mode, counts the set bits of the combined row, and accumulates that count into a candidate score per frame. Compared with the previous generation it adds:
- parametrised row and accumulator widths;
- an internal group-phase counter instead of an external count;
- OR and 3-input parity modes;
- valid/start/last framing;
- saturation with a sticky overflow flag;
- a partial-group flag.
It sits between the MapCell outputs and the candidate compare/selection logic, driven by Control.

---
 rtl/candidate_pkg.sv | 14 +
 rtl/row_combine.sv | 23 ++
 rtl/candidate_accum.sv | 75 +++++++
 tb/tb_candidate_accum.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/candidate_pkg.sv
// candidate_pkg: mode encodings, FSM states and group-size helper for candidate_accum
package candidate_pkg;
  localparam logic [2:0] MODE_POP = 3'd0;
  localparam logic [2:0] MODE_AND = 3'd1;
  localparam logic [2:0] MODE_XOR = 3'd2;
  localparam logic [2:0] MODE_MAJ = 3'd3;
  localparam logic [2:0] MODE_OR  = 3'd4;
  localparam logic [2:0] MODE_PAR = 3'd5;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic logic [1:0] group_size(input logic [2:0] mode);
    return (mode == MODE_AND || mode == MODE_XOR || mode == MODE_OR) ? 2'd2 :
           (mode == MODE_MAJ || mode == MODE_PAR) ? 2'd3 : 2'd1;
  endfunction
endpackage

// File: rtl/row_combine.sv
// row_combine: bitwise-combine up to three rows by mode and popcount the result
module row_combine import candidate_pkg::*; #(
  parameter int ROW_W = 8,
  parameter int PC_W = $clog2(ROW_W + 1)
) (
  input  logic [2:0]       mode,
  input  logic [ROW_W-1:0] r0,
  input  logic [ROW_W-1:0] r1,
  input  logic [ROW_W-1:0] r2,
  output logic [PC_W-1:0]  count
);
  logic [ROW_W-1:0] row;
  // combine per mode (reserved modes fall back to the current row) then count ones
  always_comb begin
    row = mode == MODE_AND ? r0 & r1 :
          mode == MODE_XOR ? r0 ^ r1 :
          mode == MODE_MAJ ? (r0 & r1) | (r0 & r2) | (r1 & r2) :
          mode == MODE_OR  ? r0 | r1 :
          mode == MODE_PAR ? r0 ^ r1 ^ r2 : r0;
    count = '0;
    for (int i = 0; i < ROW_W; i++) count = count + PC_W'(row[i]);
  end
endmodule

// File: rtl/candidate_accum.sv
// candidate_accum: framed, mode-grouped popcount accumulator with saturation and sticky flags
module candidate_accum import candidate_pkg::*; #(
  parameter int ROW_W = 8,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] result,
  input  logic             result_valid,
  input  logic [2:0]       reg_mode,
  input  logic             start,
  input  logic             frame_last,
  output logic [ACC_W-1:0] candidate,
  output logic             candidate_valid,
  output logic             busy,
  output logic             overflow,
  output logic             partial
);
  localparam int PC_W = $clog2(ROW_W + 1);
  state_t           state;
  logic [2:0]       mode;
  logic [ROW_W-1:0] h1, h2;
  logic [1:0]       phase;
  logic [PC_W-1:0]  count;
  logic [ACC_W:0]   sum;
  logic             take, grp_end;
  assign take = state == ACCUM && result_valid;
  assign grp_end = phase == group_size(mode) - 2'd1;
  assign sum = {1'b0, candidate} + (ACC_W + 1)'(count);
  assign busy = state == ACCUM;
  assign candidate_valid = state == DONE;
  row_combine #(.ROW_W(ROW_W), .PC_W(PC_W)) u_combine (
    .mode (mode),
    .r0   (result),
    .r1   (h1),
    .r2   (h2),
    .count(count)
  );
  // frame FSM: start wins over everything; accepted rows shift history and close groups
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      mode <= MODE_POP;
      h1 <= '0;
      h2 <= '0;
      phase <= '0;
      candidate <= '0;
      overflow <= 1'b0;
      partial <= 1'b0;
    end else if (start) begin
      state <= ACCUM;
      mode <= reg_mode;
      h1 <= '0;
      h2 <= '0;
      phase <= '0;
      candidate <= '0;
      overflow <= 1'b0;
      partial <= 1'b0;
    end else if (take) begin
      h1 <= result;
      h2 <= h1;
      phase <= grp_end ? 2'd0 : phase + 2'd1;
      if (grp_end) begin
        candidate <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        overflow <= overflow | sum[ACC_W];
      end
      if (frame_last) begin
        state <= DONE;
        partial <= partial | !grp_end;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_candidate_accum.sv
// tb_candidate_accum: randomized scoreboard bench against a frame-level reference model
module tb_candidate_accum;
  typedef logic [7:0] row_q_t[$];
  logic       clk = 0;
  logic       rst = 0;
  logic [7:0] result = 0;
  logic       result_valid = 0;
  logic [2:0] reg_mode = 0;
  logic       start = 0;
  logic       frame_last = 0;
  logic [7:0] candidate;
  logic       candidate_valid, busy, overflow, partial;
  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];

  candidate_accum #(.ROW_W(8), .ACC_W(8)) dut (
    .clk(clk), .rst(rst), .result(result), .result_valid(result_valid),
    .reg_mode(reg_mode), .start(start), .frame_last(frame_last),
    .candidate(candidate), .candidate_valid(candidate_valid), .busy(busy),
    .overflow(overflow), .partial(partial)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gsize(input int m);
    return (m == 1 || m == 2 || m == 4) ? 2 : (m == 3 || m == 5) ? 3 : 1;
  endfunction

  function automatic logic [7:0] comb(input int m, input logic [7:0] a, b, c);
    case (m)
      1: return a & b;
      2: return a ^ b;
      3: return (a & b) | (a & c) | (b & c);
      4: return a | b;
      5: return a ^ b ^ c;
      default: return a;
    endcase
  endfunction

  function automatic int total(input int m, input row_q_t rows);
    int g = gsize(m);
    int n = rows.size() / g * g;
    int t = 0;
    for (int k = 0; k < n; k += g)
      t += $countones(comb(m, rows[k], (g > 1) ? rows[k+1] : 8'h00, (g > 2) ? rows[k+2] : 8'h00));
    return t;
  endfunction

  function automatic int clamp(input int t);
    return t > 255 ? 255 : t;
  endfunction

  always @(negedge clk) begin
    if (rst && candidate_valid) begin
      if (exp_q.size() == 0) chk("unexpected_candidate_valid", 1, 0);
      else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("frame_candidate", candidate, e[9:2]);
        chk("frame_overflow", overflow, e[1]);
        chk("frame_partial", partial, e[0]);
      end
    end
  end

  task automatic run_frame(input int m, input row_q_t rows, input bit gaps, input bit clash);
    row_q_t acc;
    int t;
    start = 1;
    reg_mode = m[2:0];
    result_valid = clash;
    result = 8'($urandom);
    @(posedge clk); #1;
    start = 0;
    result_valid = 0;
    chk("start_busy", busy, 1);
    chk("start_candidate", candidate, 0);
    foreach (rows[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      result = rows[i];
      result_valid = 1;
      frame_last = i == rows.size() - 1;
      acc.push_back(rows[i]);
      t = total(m, acc);
      if (frame_last) exp_q.push_back({8'(clamp(t)), t > 255, acc.size() % gsize(m) != 0});
      @(posedge clk); #1;
      result_valid = 0;
      frame_last = 0;
      chk("running_candidate", candidate, clamp(t));
    end
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    row_q_t rows;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_candidate", candidate, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_partial", partial, 0);
    chk("reset_valid", candidate_valid, 0);
    rst = 1;
    @(posedge clk); #1;
    run_frame(0, '{8'hFF, 8'h0F, 8'h01}, 0, 0);
    run_frame(1, '{8'hF0, 8'hFF, 8'h0F, 8'h03}, 0, 0);
    run_frame(1, '{8'hF0, 8'hFF, 8'h0F, 8'h03}, 1, 0);
    run_frame(3, '{8'h0F, 8'h33, 8'h55}, 0, 0);
    run_frame(5, '{8'h0F, 8'h33, 8'h55}, 0, 0);
    rows = {};
    repeat (33) rows.push_back(8'hFF);
    run_frame(0, rows, 0, 0);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("restart_candidate", candidate, 0);
    chk("restart_overflow", overflow, 0);
    run_frame(2, '{8'hFF, 8'h00, 8'hAA}, 0, 0);
    run_frame(2, '{8'h0F, 8'hF0, 8'h33}, 0, 1);
    start = 1;
    reg_mode = 3'd0;
    @(posedge clk); #1;
    start = 0;
    result = 8'hFF;
    result_valid = 1;
    repeat (2) begin @(posedge clk); #1; end
    result_valid = 0;
    chk("midframe_candidate", candidate, 16);
    #2 rst = 0;
    #1;
    chk("async_reset_candidate", candidate, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_valid", candidate_valid, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    for (int f = 0; f < 25; f++) begin
      rows = {};
      repeat ($urandom_range(1, 9)) rows.push_back(8'($urandom));
      run_frame(int'($urandom_range(0, 7)), rows, 1'($urandom), 1'($urandom));
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    if (exp_q.size() != 0) chk("pending_frames", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
